regfile_write_arbiter: RTL and testbench

Schedules result writes from several execution units onto the limited write ports of the 64-entry physical register file. Each requester gets a one-entry holding buffer with a valid/ready handshake. A round-robin picker grants up to `NUM_PORTS` buffered results per cycle and drives registered write-port signals (enable, select, data) straight into the register file. It sits between the execution-unit result buses and the register file write ports.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/regfile_write_arbiter_pick.sv | 61 ++++++
 rtl/regfile_write_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file write-port constants, types and helpers
package rf_pkg;

    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;
    localparam int PHYS_REGS = 64;

    // One register-file write port as seen by the register file
    typedef struct packed {
        logic              en;
        logic [TAG_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } rf_write_t;

    // Increment an index with wrap-around at n (n need not be a power of two)
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_pick.sv
// rtl/regfile_write_arbiter_pick.sv - combinational round-robin multi-grant picker with tag-conflict skip
module rf_wr_rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = 6,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_REQ-1:0]         cand,
    input  logic [NUM_REQ*TAG_W-1:0]   tags,
    input  logic [IDX_W-1:0]           rr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_PORTS-1:0]       portValid,
    output logic [NUM_PORTS*IDX_W-1:0] portIdx,
    output logic [IDX_W-1:0]           rrNext
);
    import rf_pkg::*;

    logic [TAG_W-1:0] grantedTag [NUM_PORTS];
    logic [TAG_W-1:0] candTag;
    logic             conflict;
    int               count;
    int               idx;

    // Walk requesters from rr upward; hand out ports in scan order, skipping
    // any candidate whose tag is already being written this cycle.
    always_comb begin
        grant     = '0;
        portValid = '0;
        portIdx   = '0;
        rrNext    = rr;
        count     = 0;
        idx       = 0;
        conflict  = 1'b0;
        candTag   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            grantedTag[p] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = int'(rr) + j;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            candTag  = tags[idx*TAG_W +: TAG_W];
            conflict = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (p < count && grantedTag[p] == candTag) begin
                    conflict = 1'b1;
                end
            end
            if (cand[idx] && count < NUM_PORTS && !conflict) begin
                grant[idx]                   = 1'b1;
                portValid[count]             = 1'b1;
                portIdx[count*IDX_W +: IDX_W] = IDX_W'(idx);
                grantedTag[count]            = candTag;
                rrNext                       = IDX_W'(wrapInc(idx, NUM_REQ));
                count                        = count + 1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - buffers execution-unit results and schedules them onto register-file write ports
module regfile_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORTS = 2,
    parameter int TAG_W     = rf_pkg::TAG_W,
    parameter int DATA_W    = rf_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        commitAllow,
    input  logic [NUM_REQ-1:0]          reqValid,
    input  logic [NUM_REQ*TAG_W-1:0]    reqTag,
    input  logic [NUM_REQ*DATA_W-1:0]   reqData,
    output logic [NUM_REQ-1:0]          reqReady,
    output logic [NUM_PORTS-1:0]        writeEn,
    output logic [NUM_PORTS*TAG_W-1:0]  writeSelect,
    output logic [NUM_PORTS*DATA_W-1:0] writeData,
    output logic                        busy
);
    import rf_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          full;
    logic [NUM_REQ*TAG_W-1:0]    tagQ;
    logic [NUM_REQ*DATA_W-1:0]   dataQ;
    logic [IDX_W-1:0]            rr;
    logic [IDX_W-1:0]            rrNext;
    logic [NUM_REQ-1:0]          cand;
    logic [NUM_REQ-1:0]          grant;
    logic [NUM_REQ-1:0]          accept;
    logic [NUM_PORTS-1:0]        portValid;
    logic [NUM_PORTS*IDX_W-1:0]  portIdx;
    logic [NUM_PORTS*TAG_W-1:0]  portTag;
    logic [NUM_PORTS*DATA_W-1:0] portData;

    // Only buffered results compete, and only while commits are allowed
    assign cand = full & {NUM_REQ{commitAllow & en}};

    // A buffer being drained this cycle can take a new result at the same edge
    assign reqReady = {NUM_REQ{en & ~reset}} & (~full | grant);
    assign accept   = reqValid & reqReady;
    assign busy     = |full;

    rf_wr_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .NUM_PORTS (NUM_PORTS),
        .TAG_W     (TAG_W),
        .IDX_W     (IDX_W)
    ) u_pick (
        .cand      (cand),
        .tags      (tagQ),
        .rr        (rr),
        .grant     (grant),
        .portValid (portValid),
        .portIdx   (portIdx),
        .rrNext    (rrNext)
    );

    // Route the granted buffer contents to each write port
    always_comb begin
        portTag  = '0;
        portData = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            portTag[k*TAG_W +: TAG_W]    = tagQ[int'(portIdx[k*IDX_W +: IDX_W])*TAG_W +: TAG_W];
            portData[k*DATA_W +: DATA_W] = dataQ[int'(portIdx[k*IDX_W +: IDX_W])*DATA_W +: DATA_W];
        end
    end

    // Buffer payloads load on a completed handshake; occupancy lives below
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
                tagQ[i*TAG_W +: TAG_W]    <= reqTag[i*TAG_W +: TAG_W];
                dataQ[i*DATA_W +: DATA_W] <= reqData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Occupancy, round-robin pointer and registered write ports; all hold while en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            full        <= '0;
            rr          <= '0;
            writeEn     <= '0;
            writeSelect <= '0;
            writeData   <= '0;
        end else if (en) begin
            full    <= (full & ~grant) | accept;
            rr      <= rrNext;
            writeEn <= portValid;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (portValid[k]) begin
                    writeSelect[k*TAG_W +: TAG_W]  <= portTag[k*TAG_W +: TAG_W];
                    writeData[k*DATA_W +: DATA_W] <= portData[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         commitAllow;
    logic [3:0]   reqValid;
    logic [23:0]  reqTag;
    logic [127:0] reqData;
    logic [3:0]   reqReady;
    logic [1:0]   writeEn;
    logic [11:0]  writeSelect;
    logic [63:0]  writeData;
    logic         busy;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .NUM_REQ   (4),
        .NUM_PORTS (2),
        .TAG_W     (6),
        .DATA_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .commitAllow (commitAllow),
        .reqValid    (reqValid),
        .reqTag      (reqTag),
        .reqData     (reqData),
        .reqReady    (reqReady),
        .writeEn     (writeEn),
        .writeSelect (writeSelect),
        .writeData   (writeData),
        .busy        (busy)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        ca;
        logic [3:0]  valid;
        logic [23:0] tags;
        logic [31:0] dbase;
        logic [3:0]  expReady;
        logic [1:0]  expWe;
        logic [11:0] expSel;
        logic [63:0] expData;
        logic        expBusy;
    } vec_t;

    vec_t rows[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model state
    logic       mFull [4];
    logic [5:0] mTag  [4];
    logic [31:0] mData [4];
    int         mRr;
    logic [1:0] mWe;
    logic [11:0] mSel;
    logic [63:0] mDat;
    logic [3:0] mReady;
    int         picks[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [23:0] tags4(input int t0, input int t1, input int t2, input int t3);
        return {6'(t3), 6'(t2), 6'(t1), 6'(t0)};
    endfunction

    task automatic add(input logic rst, input logic e, input logic ca, input logic [3:0] v,
                       input logic [23:0] t, input logic [31:0] db, input logic [3:0] rdy,
                       input logic [1:0] we, input int s1, input int s0,
                       input logic [31:0] d1, input logic [31:0] d0, input logic b);
        vec_t r;
        r.rst = rst; r.en = e; r.ca = ca; r.valid = v; r.tags = t; r.dbase = db;
        r.expReady = rdy; r.expWe = we; r.expSel = {6'(s1), 6'(s0)};
        r.expData = {d1, d0}; r.expBusy = b;
        rows.push_back(r);
    endtask

    // Choose up to two full buffers in rotating priority order, never two with the same tag
    task automatic modelPick(input logic ca, input logic e);
        int i;
        bit hit;
        picks.delete();
        for (int j = 0; j < 4; j++) begin
            i = (mRr + j) % 4;
            if (mFull[i] && ca && e && picks.size() < 2) begin
                hit = 0;
                foreach (picks[p]) if (mTag[picks[p]] == mTag[i]) hit = 1;
                if (!hit) picks.push_back(i);
            end
        end
    endtask

    function automatic bit isPicked(input int i);
        foreach (picks[p]) if (picks[p] == i) return 1;
        return 0;
    endfunction

    initial begin
        // reset, idle
        add(1,1,1,4'b0000, 0, 0, 4'b0000, 2'b00, 0,0, 0,0, 0);
        add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b00, 0,0, 0,0, 0);
        // single write from requester 2
        add(0,1,1,4'b0100, tags4(0,0,5,0), 32'hDEADBEED, 4'b1111, 2'b00, 0,0, 0,0, 1);
        add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b01, 0,5, 0,32'hDEADBEEF, 0);
        add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b00, 0,0, 0,0, 0);
        // tag conflict on tag 9
        add(0,1,1,4'b0011, tags4(9,9,0,0), 32'h1, 4'b1111, 2'b00, 0,0, 0,0, 1);
        add(0,1,1,4'b0000, 0, 0, 4'b1101, 2'b01, 0,9, 0,32'h1, 1);
        add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b01, 0,9, 0,32'h2, 0);
        add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b00, 0,0, 0,0, 0);
        // contention, all four valid
        add(1,1,1,4'b0000, 0, 0, 4'b0000, 2'b00, 0,0, 0,0, 0);
        add(0,1,1,4'b1111, tags4(10,11,12,13), 32'h100, 4'b1111, 2'b00, 0,0, 0,0, 1);
        add(0,1,1,4'b1111, tags4(10,11,12,13), 32'h100, 4'b0011, 2'b11, 11,10, 32'h101,32'h100, 1);
        add(0,1,1,4'b1111, tags4(10,11,12,13), 32'h100, 4'b1100, 2'b11, 13,12, 32'h103,32'h102, 1);
        add(0,1,1,4'b1111, tags4(10,11,12,13), 32'h100, 4'b0011, 2'b11, 11,10, 32'h101,32'h100, 1);
        add(0,1,1,4'b0000, 0, 0, 4'b1100, 2'b11, 13,12, 32'h103,32'h102, 1);
        add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b11, 11,10, 32'h101,32'h100, 0);
        // commitAllow low for three cycles
        add(0,1,0,4'b1111, tags4(20,21,22,23), 32'h200, 4'b1111, 2'b00, 0,0, 0,0, 1);
        add(0,1,0,4'b1111, tags4(20,21,22,23), 32'h200, 4'b0000, 2'b00, 0,0, 0,0, 1);
        add(0,1,0,4'b1111, tags4(20,21,22,23), 32'h200, 4'b0000, 2'b00, 0,0, 0,0, 1);
        add(0,1,1,4'b0000, 0, 0, 4'b1100, 2'b11, 23,22, 32'h203,32'h202, 1);
        add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b11, 21,20, 32'h201,32'h200, 0);
        // reset while three buffers are full and both ports are writing
        add(0,1,1,4'b1111, tags4(30,31,32,33), 32'h300, 4'b1111, 2'b00, 0,0, 0,0, 1);
        add(0,1,1,4'b0100, tags4(0,0,42,0), 32'h400, 4'b1100, 2'b11, 33,32, 32'h303,32'h302, 1);
        add(1,1,1,4'b0000, 0, 0, 4'b0000, 2'b00, 0,0, 0,0, 0);
        for (int n = 0; n < 4; n++)
            add(0,1,1,4'b0000, 0, 0, 4'b1111, 2'b00, 0,0, 0,0, 0);

        for (int r = 0; r < rows.size(); r++) begin
            reset       = rows[r].rst;
            en          = rows[r].en;
            commitAllow = rows[r].ca;
            reqValid    = rows[r].valid;
            reqTag      = rows[r].tags;
            for (int i = 0; i < 4; i++) reqData[i*32 +: 32] = rows[r].dbase + 32'(i);
            #1;
            chk($sformatf("row%0d reqReady", r), 64'(reqReady), 64'(rows[r].expReady));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d writeEn", r), 64'(writeEn), 64'(rows[r].expWe));
            chk($sformatf("row%0d busy", r), 64'(busy), 64'(rows[r].expBusy));
            for (int k = 0; k < 2; k++) begin
                if (rows[r].expWe[k]) begin
                    chk($sformatf("row%0d sel%0d", r, k), 64'(writeSelect[k*6 +: 6]), 64'(rows[r].expSel[k*6 +: 6]));
                    chk($sformatf("row%0d data%0d", r, k), 64'(writeData[k*32 +: 32]), 64'(rows[r].expData[k*32 +: 32]));
                end
            end
            if (r == 0) begin
                chk("reset writeSelect", 64'(writeSelect), 64'd0);
                chk("reset writeData", writeData, 64'd0);
            end
        end

        // Randomised phase against the reference model
        for (int i = 0; i < 4; i++) begin
            mFull[i] = 0; mTag[i] = 0; mData[i] = 0;
        end
        mRr = 0; mWe = 0; mSel = 0; mDat = 0;
        for (int c = 0; c < 1500; c++) begin
            reset       = (c == 0) || ($urandom_range(0, 49) == 0);
            en          = ($urandom_range(0, 7) != 0);
            commitAllow = ($urandom_range(0, 4) != 0);
            reqValid    = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                reqTag[i*6 +: 6]   = 6'($urandom_range(0, 3));
                reqData[i*32 +: 32] = $urandom;
            end
            #1;
            modelPick(commitAllow, en);
            for (int i = 0; i < 4; i++)
                mReady[i] = en & ~reset & (~mFull[i] | isPicked(i));
            chk("rand reqReady", 64'(reqReady), 64'(mReady));
            chk("rand busy", 64'(busy), 64'(mFull[0] | mFull[1] | mFull[2] | mFull[3]));
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 4; i++) mFull[i] = 0;
                mRr = 0; mWe = 0; mSel = 0; mDat = 0;
            end else if (en) begin
                for (int k = 0; k < 2; k++) begin
                    if (k < picks.size()) begin
                        mWe[k] = 1'b1;
                        mSel[k*6 +: 6] = mTag[picks[k]];
                        mDat[k*32 +: 32] = mData[picks[k]];
                    end else begin
                        mWe[k] = 1'b0;
                    end
                end
                if (picks.size() > 0) mRr = (picks[picks.size()-1] + 1) % 4;
                for (int i = 0; i < 4; i++) begin
                    if (isPicked(i)) mFull[i] = 0;
                    if (reqValid[i] && mReady[i]) begin
                        mFull[i] = 1;
                        mTag[i]  = reqTag[i*6 +: 6];
                        mData[i] = reqData[i*32 +: 32];
                    end
                end
            end
            #1;
            chk("rand writeEn", 64'(writeEn), 64'(mWe));
            chk("rand writeSelect", 64'(writeSelect), 64'(mSel));
            chk("rand writeData", writeData, mDat);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
